// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core's icache refill path.
package bsg_vanilla_pkg;

    // Refill sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } icache_refill_state_e;

    // Widest word address any icache configuration in this core uses.
    localparam int unsigned icache_refill_addr_width_gp = 32;

    // One word-read request to the memory network.
    typedef struct packed {
        logic [icache_refill_addr_width_gp-1:0] addr;
    } icache_refill_req_s;

endpackage

// File: rtl/icache_refill_ctrl_reorder_buf.sv
// Reorder buffer for one icache block: words land by block offset in any
// order and are popped strictly in ascending offset order.
module icache_refill_reorder_buf #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 32,
    localparam int unsigned offset_width_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       wr_v_i,
    input  logic [offset_width_lp-1:0] wr_offset_i,
    input  logic [width_p-1:0]         wr_data_i,
    input  logic [offset_width_lp-1:0] rd_offset_i,
    input  logic                       pop_i,
    output logic                       rd_v_o,
    output logic [width_p-1:0]         rd_data_o
);

    logic [els_p-1:0]   valid_r;
    logic [width_p-1:0] data_r [els_p];

    // Valid bits: set on arrival, cleared on pop or at the start of a refill.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            valid_r <= '0;
        end else begin
            if (pop_i) begin
                valid_r[rd_offset_i] <= 1'b0;
            end
            if (wr_v_i) begin
                valid_r[wr_offset_i] <= 1'b1;
            end
        end
    end

    // Data array: no reset needed, every read is qualified by its valid bit.
    always_ff @(posedge clk_i) begin
        if (wr_v_i) begin
            data_r[wr_offset_i] <= wr_data_i;
        end
    end

    assign rd_v_o    = valid_r[rd_offset_i];
    assign rd_data_o = data_r[rd_offset_i];

`ifndef SYNTHESIS
    // A second response for an offset still held means the network duplicated a word.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !clear_i && wr_v_i && valid_r[wr_offset_i]) begin
            $error("icache_refill_reorder_buf: response to already-valid offset %0d", wr_offset_i);
        end
    end
`endif

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache block refill sequencer: issues one read per word of the missing
// block, accepts out-of-order responses, and writes the icache in order.
module icache_refill_ctrl
    import bsg_vanilla_pkg::*;
#(
    parameter int unsigned icache_tag_width_p           = 12,
    parameter int unsigned icache_entries_p             = 1024,
    parameter int unsigned icache_block_size_in_words_p = 4,
    localparam int unsigned pc_width_lp           = icache_tag_width_p + $clog2(icache_entries_p),
    localparam int unsigned block_offset_width_lp = $clog2(icache_block_size_in_words_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             miss_v_i,
    input  logic [pc_width_lp-1:0]           miss_pc_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             req_v_o,
    output logic [pc_width_lp-1:0]           req_addr_o,
    input  logic                             req_ready_i,
    input  logic                             resp_v_i,
    input  logic [block_offset_width_lp-1:0] resp_offset_i,
    input  logic [31:0]                      resp_data_i,
    output logic                             icache_v_o,
    output logic                             icache_w_o,
    output logic [pc_width_lp-1:0]           icache_w_pc_o,
    output logic [31:0]                      icache_w_instr_o
);

    localparam int unsigned cnt_width_lp = block_offset_width_lp + 1;
    localparam logic [cnt_width_lp-1:0] block_size_lp  = cnt_width_lp'(icache_block_size_in_words_p);
    localparam logic [cnt_width_lp-1:0] last_offset_lp = cnt_width_lp'(icache_block_size_in_words_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp     = cnt_width_lp'(1);
    localparam logic [pc_width_lp-1:0]  offset_mask_lp = pc_width_lp'(icache_block_size_in_words_p - 1);

    icache_refill_state_e        state_r;
    logic [pc_width_lp-1:0]      base_r;
    logic [cnt_width_lp-1:0]     req_cnt_r;
    logic [cnt_width_lp-1:0]     wr_cnt_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        req_v_r;
    logic [pc_width_lp-1:0]      req_addr_r;

    logic [pc_width_lp-1:0]      miss_base;
    logic [cnt_width_lp-1:0]     req_cnt_next;
    logic [cnt_width_lp-1:0]     wr_cnt_next;
    logic                        req_fire;
    logic                        in_refill;
    logic                        buf_wr_v;
    logic                        buf_clear;
    logic                        buf_rd_v;
    logic [31:0]                 buf_rd_data;
    logic                        icache_v;

    // Masking (not adding) keeps the offset arithmetic from ever carrying into the tag.
    assign miss_base    = miss_pc_i & ~offset_mask_lp;
    assign req_cnt_next = req_cnt_r + cnt_one_lp;
    assign wr_cnt_next  = wr_cnt_r + cnt_one_lp;
    assign req_fire     = req_v_r & req_ready_i;
    assign in_refill    = (state_r == REFILL);
    assign buf_wr_v     = in_refill & resp_v_i;
    assign buf_clear    = (state_r == IDLE) & miss_v_i;
    assign icache_v     = in_refill & buf_rd_v;

    icache_refill_reorder_buf #(
        .els_p   (icache_block_size_in_words_p),
        .width_p (32)
    ) reorder_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     (buf_clear),
        .wr_v_i      (buf_wr_v),
        .wr_offset_i (resp_offset_i),
        .wr_data_i   (resp_data_i),
        .rd_offset_i (wr_cnt_r[block_offset_width_lp-1:0]),
        .pop_i       (icache_v),
        .rd_v_o      (buf_rd_v),
        .rd_data_o   (buf_rd_data)
    );

    // Refill FSM with request counter, write counter and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            base_r     <= '0;
            req_cnt_r  <= '0;
            wr_cnt_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            req_v_r    <= 1'b0;
            req_addr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (miss_v_i) begin
                        state_r    <= REFILL;
                        base_r     <= miss_base;
                        req_cnt_r  <= '0;
                        wr_cnt_r   <= '0;
                        busy_r     <= 1'b1;
                        req_v_r    <= 1'b1;
                        req_addr_r <= miss_base;
                    end
                end
                REFILL: begin
                    if (req_fire) begin
                        req_cnt_r <= req_cnt_next;
                        if (req_cnt_next == block_size_lp) begin
                            req_v_r <= 1'b0;
                        end else begin
                            req_addr_r <= base_r | pc_width_lp'(req_cnt_next[block_offset_width_lp-1:0]);
                        end
                    end
                    if (icache_v) begin
                        wr_cnt_r <= wr_cnt_next;
                        if (wr_cnt_r == last_offset_lp) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            req_v_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    req_v_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o           = busy_r;
    assign done_o           = done_r;
    assign req_v_o          = req_v_r;
    assign req_addr_o       = req_addr_r;
    assign icache_v_o       = icache_v;
    assign icache_w_o       = icache_v;
    assign icache_w_pc_o    = icache_v ? (base_r | pc_width_lp'(wr_cnt_r[block_offset_width_lp-1:0])) : '0;
    assign icache_w_instr_o = icache_v ? buf_rd_data : '0;

`ifndef SYNTHESIS
    // Responses outside a refill, or for words never requested, indicate a network fault.
    always_ff @(posedge clk_i) begin
        if (!reset_i && resp_v_i) begin
            if (!in_refill) begin
                $error("icache_refill_ctrl: response dropped outside REFILL");
            end else if ({1'b0, resp_offset_i} >= req_cnt_r) begin
                $error("icache_refill_ctrl: response to unrequested offset %0d", resp_offset_i);
            end
        end
    end
`endif

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequences an icache block refill after the fetch stage reports a miss.
- Issues one word-read request per word of the missing block to the memory network. Responses may return out of order.
- Reorders returned words in a small buffer and writes them into the icache in strict ascending block-offset order, which is the order the icache write port requires.
- Sits between the fetch stage (miss/flush) and the icache write port (v/w/w_pc/w_instr).

Parameters:
- icache_tag_width_p, 12: tag width. Must match the icache.
- icache_entries_p, 1024: icache size in words. Must match the icache.
- icache_block_size_in_words_p, 4: words per block. Power of 2, ≥2.
- pc_width_lp, localparam: icache_tag_width_p + clog2(icache_entries_p). Word address width.
- block_offset_width_lp, localparam: clog2(icache_block_size_in_words_p).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- miss_v_i  in  1  fetch reports an icache miss this cycle
- miss_pc_i  in  pc_width_lp  word PC that missed
- busy_o  out  1  refill in progress; fetch must stall
- done_o  out  1  one-cycle pulse after the last word is written
- req_v_o  out  1  memory read request valid
- req_addr_o  out  pc_width_lp  word address of the request
- req_ready_i  in  1  network accepts the request this cycle
- resp_v_i  in  1  read response valid; always accepted
- resp_offset_i  in  block_offset_width_lp  block offset of the returning word
- resp_data_i  in  32  returned instruction word
- icache_v_o  out  1  icache write valid
- icache_w_o  out  1  icache write enable; equals icache_v_o
- icache_w_pc_o  out  pc_width_lp  word PC being written
- icache_w_instr_o  out  32  instruction being written

Behaviour:
- One clock (clk_i). Reset (reset_i) is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - All outputs 0: busy_o, done_o, req_v_o, icache_v_o, icache_w_o.
  - req_addr_o, icache_w_pc_o, icache_w_instr_o = 0.
  - Valid bits cleared; req_cnt = wr_cnt = 0.
- Base register: base_r = {miss_pc_i[pc_width_lp-1:block_offset_width_lp], 0s}, latched on miss acceptance.
- FSM states IDLE, REFILL, DONE:
  - IDLE:
    - miss_v_i=1 → latch base_r, clear valid bits, req_cnt=wr_cnt=0, go to REFILL.
    - busy_o rises the cycle after miss_v_i.
  - REFILL:
    - busy_o=1.
    - Requests:
      - req_v_o=1 while req_cnt < block size.
      - req_addr_o = base_r | req_cnt.
      - req_v_o & req_ready_i → req_cnt++.
      - Requests go out in ascending offset order, one per cycle maximum.
    - Responses:
      - resp_v_i writes buf[resp_offset_i] and sets valid[resp_offset_i].
    - Writes:
      - icache_v_o = icache_w_o = valid[wr_cnt], registered-buffer based. Minimum latency is response → write on the next cycle.
      - icache_w_pc_o = base_r | wr_cnt; icache_w_instr_o = buf[wr_cnt].
      - Each write increments wr_cnt and clears valid[wr_cnt].
      - At most one icache write per cycle.
    - Write of offset block_size-1 → go to DONE.
  - DONE:
    - done_o=1 for exactly one cycle; busy_o=0.
    - Go to IDLE.
    - miss_v_i is ignored in DONE.
- Boundary conditions:
  - miss_v_i while REFILL or DONE: ignored. Fetch must re-assert after done_o.
  - Response arriving on the same cycle a write drains a different offset: both proceed.
  - Response for the offset currently at wr_cnt, arriving while valid[wr_cnt]=0: stored, written next cycle.
  - resp_v_i in IDLE or DONE: dropped. Simulation-only $error.
  - resp_v_i to an offset already valid, or to an offset not yet requested: $error.
  - req_cnt and wr_cnt saturate at block size; there is no wrap within a refill.
  - Base address arithmetic is an OR into the zeroed offset field, so there is never a carry into the tag.
  - reset_i mid-refill: returns to IDLE the next cycle and kills outstanding state. The network is separately reset, so stale responses are not expected.
- The icache's own write counter relies on exactly icache_block_size_in_words_p writes per refill, offsets 0..N-1 in order. This block guarantees that.

Decomposition:
- Shared package bsg_vanilla_pkg:
  - Refill FSM state enum: icache_refill_state_e {IDLE, REFILL, DONE}.
  - Memory request struct: icache_refill_req_s {addr}.
- One natural sub-module: icache_refill_reorder_buf.
  - Per-offset valid bits plus data array.
  - Write port by offset, in-order read/pop port at wr_cnt.
  - Clear input.
- The FSM and request counter live in the top.

Test Plan (block size 4):
- In-order refill:
  - Stimulus: miss_pc_i=0x1236, ready always 1, responses offsets 0,1,2,3 one per cycle, 2 cycles after each request.
  - Required: req_addr_o = 0x1234..0x1237 on consecutive cycles; icache writes PCs 0x1234..0x1237 in order; done_o one cycle after the last write.
- Reversed responses:
  - Stimulus: responses return offsets 3,2,1,0.
  - Required: no icache write until offset 0 arrives; then 4 writes on 4 consecutive cycles, PCs 0x1234..0x1237, data matched per offset.
- Backpressure:
  - Stimulus: req_ready_i toggles 1,0,0,1,0,1,1.
  - Required: exactly 4 requests accepted, addresses ascending, req_addr_o stable while stalled.
- Ignored miss:
  - Stimulus: second miss_v_i (pc 0x2000) during REFILL.
  - Required: no requests to 0x2000; after done_o, a new miss to 0x2000 refills 0x2000..0x2003.
- Reset mid-refill:
  - Stimulus: reset_i after 2 writes.
  - Required: next cycle all outputs 0, FSM IDLE; a fresh miss restarts at offset 0.
- Same-cycle response and drain:
  - Stimulus: response for offset 2 arrives in the same cycle that offset 1 is written.
  - Required: offset 2 is written on the next cycle with no bubble.
